contadores_multi: RTL and testbench

CONTADORES_MULTI -- requirements
Module: contadores_multi

---
 rtl/contadores_multi_if.sv | 28 ++
 rtl/contadores_multi.sv | 90 +++++++++
 tb/tb_contadores_multi.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/contadores_multi_if.sv
// Request/response bundle for contadores_multi: per-channel push/pop,
// the read port, and the sticky status flags.
interface contadores_multi_if #(
  parameter int NCH   = 4,
  parameter int CBITS = 5,
  parameter int IDXW  = 2
);
  logic [NCH-1:0]   push;
  logic [NCH-1:0]   pop;
  logic             idle;
  logic             req;
  logic [IDXW-1:0]  idx;
  logic             clr_rd;
  logic [CBITS-1:0] counter_out;
  logic             valid_out;
  logic [NCH-1:0]   ovf;
  logic [NCH-1:0]   unf;

  modport master (
    output push, pop, idle, req, idx, clr_rd,
    input  counter_out, valid_out, ovf, unf
  );

  modport slave (
    input  push, pop, idle, req, idx, clr_rd,
    output counter_out, valid_out, ovf, unf
  );
endinterface

// File: rtl/contadores_multi.sv
// Bank of NCH independent up/down counters with sticky overflow/underflow
// flags and a one-cycle-latency indexed read port with optional clear.
module contadores_multi #(
  parameter int NCH   = 4,
  parameter int CBITS = 5,
  parameter int IDXW  = 2,
  parameter int SAT   = 0
) (
  input  logic              clk,
  input  logic              reset,
  contadores_multi_if.slave bus
);

  localparam logic [CBITS-1:0] MAXV = '1;

  logic [CBITS-1:0] cnt_q [NCH];
  logic [CBITS-1:0] cnt_d [NCH];
  logic [NCH-1:0]   ovf_q, ovf_d;
  logic [NCH-1:0]   unf_q, unf_d;
  logic [CBITS-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  logic             accept;
  logic [NCH-1:0]   inc, dec, clr;

  // Next-state for every channel plus the read response.
  // Flag events come from the pre-clear count, so a clear-on-read cannot
  // itself fabricate an underflow; the count result uses the cleared base.
  always_comb begin
    accept     = bus.idle & bus.req;
    rd_valid_d = accept;
    rd_data_d  = '0;
    inc        = '0;
    dec        = '0;
    clr        = '0;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;

    for (int unsigned i = 0; i < NCH; i++) begin
      inc[i] = bus.push[i] & ~bus.pop[i];
      dec[i] = bus.pop[i] & ~bus.push[i];
      clr[i] = accept & bus.clr_rd & (bus.idx == IDXW'(i));

      // Out-of-range indices match no channel and therefore return zero.
      if (accept && (bus.idx == IDXW'(i)))
        rd_data_d = cnt_q[i];

      if (clr[i]) begin
        cnt_d[i] = inc[i] ? CBITS'(1) : '0;
      end else if (inc[i]) begin
        if (cnt_q[i] == MAXV)
          cnt_d[i] = (SAT != 0) ? MAXV : '0;
        else
          cnt_d[i] = cnt_q[i] + CBITS'(1);
      end else if (dec[i]) begin
        if (cnt_q[i] != '0)
          cnt_d[i] = cnt_q[i] - CBITS'(1);
      end

      ovf_d[i] = (ovf_q[i] & ~clr[i]) | (inc[i] & (cnt_q[i] == MAXV));
      unf_d[i] = (unf_q[i] & ~clr[i]) | (dec[i] & (cnt_q[i] == '0));
    end
  end

  // State registers; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NCH; i++)
        cnt_q[i] <= '0;
      ovf_q      <= '0;
      unf_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++)
        cnt_q[i] <= cnt_d[i];
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.counter_out = rd_data_q;
  assign bus.valid_out   = rd_valid_q;
  assign bus.ovf         = ovf_q;
  assign bus.unf         = unf_q;

endmodule

// File: tb/tb_contadores_multi.sv
// Directed bench: instance A (NCH=4, wrap) and instance B (NCH=3, saturate)
// receive the same stimulus; B sees only push/pop bits [2:0].
module tb_contadores_multi;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] push_t, pop_t;
  logic       idle_t, req_t, clr_t;
  logic [1:0] idx_t;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  contadores_multi_if #(.NCH(4), .CBITS(5), .IDXW(2)) bus_a ();
  contadores_multi_if #(.NCH(3), .CBITS(5), .IDXW(2)) bus_b ();

  assign bus_a.push   = push_t;
  assign bus_a.pop    = pop_t;
  assign bus_a.idle   = idle_t;
  assign bus_a.req    = req_t;
  assign bus_a.idx    = idx_t;
  assign bus_a.clr_rd = clr_t;
  assign bus_b.push   = push_t[2:0];
  assign bus_b.pop    = pop_t[2:0];
  assign bus_b.idle   = idle_t;
  assign bus_b.req    = req_t;
  assign bus_b.idx    = idx_t;
  assign bus_b.clr_rd = clr_t;

  contadores_multi #(.NCH(4), .CBITS(5), .IDXW(2), .SAT(0)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  contadores_multi #(.NCH(3), .CBITS(5), .IDXW(2), .SAT(1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulses(input logic [3:0] p, input logic [3:0] q, input int n);
    push_t = p;
    pop_t  = q;
    for (int k = 0; k < n; k++) tick();
    push_t = '0;
    pop_t  = '0;
  endtask

  // One accepted read; req is left high so reads can run back-to-back.
  task automatic rd(input string tag, input logic [1:0] ix, input logic cl,
                    input logic [3:0] p, input int exp_a, input int exp_b);
    idle_t = 1'b1;
    req_t  = 1'b1;
    idx_t  = ix;
    clr_t  = cl;
    push_t = p;
    tick();
    push_t = '0;
    clr_t  = 1'b0;
    check({tag, ".va"}, 32'(bus_a.valid_out), 32'd1);
    check({tag, ".da"}, 32'(bus_a.counter_out), 32'(exp_a));
    check({tag, ".vb"}, 32'(bus_b.valid_out), 32'd1);
    check({tag, ".db"}, 32'(bus_b.counter_out), 32'(exp_b));
  endtask

  task automatic rd_end(input string tag);
    req_t = 1'b0;
    tick();
    check({tag, ".va0"}, 32'(bus_a.valid_out), 32'd0);
    check({tag, ".da0"}, 32'(bus_a.counter_out), 32'd0);
    check({tag, ".vb0"}, 32'(bus_b.valid_out), 32'd0);
  endtask

  task automatic flags(input string tag, input logic [3:0] oa, input logic [3:0] ua,
                       input logic [2:0] ob, input logic [2:0] ub);
    check({tag, ".ovfa"}, 32'(bus_a.ovf), 32'(oa));
    check({tag, ".unfa"}, 32'(bus_a.unf), 32'(ua));
    check({tag, ".ovfb"}, 32'(bus_b.ovf), 32'(ob));
    check({tag, ".unfb"}, 32'(bus_b.unf), 32'(ub));
  endtask

  initial begin
    reset  = 1'b1;
    push_t = '0;
    pop_t  = '0;
    idle_t = 1'b0;
    req_t  = 1'b0;
    idx_t  = '0;
    clr_t  = 1'b0;
    tick();
    tick();
    check("rst.va", 32'(bus_a.valid_out), 32'd0);
    check("rst.da", 32'(bus_a.counter_out), 32'd0);
    check("rst.vb", 32'(bus_b.valid_out), 32'd0);
    flags("rst", 4'b0000, 4'b0000, 3'b000, 3'b000);
    reset = 1'b0;

    // Count and read
    pulses(4'b0100, 4'b0000, 3);
    rd("cnt3", 2'd2, 1'b0, 4'b0000, 3, 3);
    rd_end("cnt3");

    // Wrap (A) vs saturate (B), then clear-on-read
    pulses(4'b0001, 4'b0000, 32);
    flags("wrap", 4'b0001, 4'b0000, 3'b001, 3'b000);
    rd("wrapclr", 2'd0, 1'b1, 4'b0000, 0, 31);
    rd_end("wrapclr");
    flags("wrapclr", 4'b0000, 4'b0000, 3'b000, 3'b000);

    // 40 pushes: A wraps to 8, B saturates at 31; back-to-back reads
    pulses(4'b0010, 4'b0000, 40);
    rd("sat1", 2'd1, 1'b0, 4'b0000, 8, 31);
    rd("b2b", 2'd2, 1'b0, 4'b0000, 3, 3);
    rd_end("b2b");
    flags("sat", 4'b0010, 4'b0000, 3'b010, 3'b000);

    // Simultaneous push/pop hold, underflow at zero, out-of-range on B
    pulses(4'b1000, 4'b0000, 5);
    pulses(4'b1000, 4'b1000, 1);
    pulses(4'b0000, 4'b0001, 1);
    flags("unf", 4'b0010, 4'b0001, 3'b010, 3'b001);
    rd("hold3", 2'd3, 1'b0, 4'b0000, 5, 0);
    rd("unf0", 2'd0, 1'b0, 4'b0000, 0, 0);
    rd_end("unf0");

    // Clear-on-read with concurrent push
    rd("clr1", 2'd1, 1'b1, 4'b0000, 8, 31);
    rd_end("clr1");
    flags("clr1", 4'b0000, 4'b0001, 3'b000, 3'b001);
    pulses(4'b0010, 4'b0000, 7);
    rd("clrpush", 2'd1, 1'b1, 4'b0010, 7, 7);
    rd("afterclr", 2'd1, 1'b0, 4'b0000, 1, 1);
    rd_end("afterclr");

    // Gating: req without idle is ignored
    idle_t = 1'b0;
    req_t  = 1'b1;
    idx_t  = 2'd2;
    tick();
    check("gate.va", 32'(bus_a.valid_out), 32'd0);
    check("gate.da", 32'(bus_a.counter_out), 32'd0);
    check("gate.vb", 32'(bus_b.valid_out), 32'd0);
    req_t = 1'b0;
    rd("gate", 2'd2, 1'b0, 4'b0000, 3, 3);
    rd_end("gate");

    // Reset mid-operation: asynchronous kill of valid_out, then all zero
    pulses(4'b1111, 4'b0000, 2);
    rd("prerst", 2'd2, 1'b0, 4'b0000, 5, 5);
    req_t = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("arst.va", 32'(bus_a.valid_out), 32'd0);
    check("arst.da", 32'(bus_a.counter_out), 32'd0);
    check("arst.vb", 32'(bus_b.valid_out), 32'd0);
    tick();
    reset = 1'b0;
    flags("postrst", 4'b0000, 4'b0000, 3'b000, 3'b000);
    rd("z0", 2'd0, 1'b0, 4'b0000, 0, 0);
    rd("z1", 2'd1, 1'b0, 4'b0000, 0, 0);
    rd("z2", 2'd2, 1'b0, 4'b0000, 0, 0);
    rd("z3", 2'd3, 1'b0, 4'b0000, 0, 0);
    rd_end("z");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
